// File: rtl/board_judge_if.sv
// Handshake and result bundle between the game-control FSM and the board judge.
// The control side drives start/board; the judge drives status and results.
interface board_judge_if #(
  parameter int N  = 3,
  parameter int AW = (N > 1) ? $clog2(N) : 1
);
  logic              start;
  logic [2*N*N-1:0]  board;
  logic              busy;
  logic              done;
  logic [1:0]        winner;
  logic              draw;
  logic              illegal;
  logic [AW-1:0]     win_row;
  logic [AW-1:0]     win_col;
  logic [1:0]        win_dir;

  modport master (
    output start, board,
    input  busy, done, winner, draw, illegal, win_row, win_col, win_dir
  );

  modport slave (
    input  start, board,
    output busy, done, winner, draw, illegal, win_row, win_col, win_dir
  );
endinterface

// File: rtl/board_judge.sv
// Sequential K-in-a-row judge for an NxN board: scans one cell per cycle,
// reports winner (player 1 preferred), its first line, draw and illegal cells.
module board_judge #(
  parameter int N  = 3,
  parameter int K  = 3,
  parameter int AW = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  board_judge_if.slave bus
);

  localparam int NC = N * N;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                  state_q, state_d;
  logic [2*NC-1:0]         board_q;
  logic [AW-1:0]           row_q, col_q;
  logic [N-1:0][N-1:0][3:0] hit1, hit2;
  logic [3:0]              cur1, cur2;
  logic                    last_cell;
  logic                    has_empty, has_illegal;
  logic                    busy_q, done_q, draw_q, illegal_q;
  logic [1:0]              winner_q, dir_q;
  logic [AW-1:0]           wrow_q, wcol_q;

  // Every (cell, direction) pair whose run fits on the board gets its own
  // K-input match; pairs that would leave the board are tied to zero.
  for (genvar gr = 0; gr < N; gr++) begin : g_row
    for (genvar gc = 0; gc < N; gc++) begin : g_col
      for (genvar gd = 0; gd < 4; gd++) begin : g_dir
        localparam int DR = (gd == 0) ? 0 : 1;
        localparam int DC = (gd == 1) ? 0 : ((gd == 3) ? -1 : 1);
        localparam int ER = gr + DR * (K - 1);
        localparam int EC = gc + DC * (K - 1);
        if (ER < N && EC >= 0 && EC < N) begin : g_run
          logic [K-1:0] is1, is2;
          for (genvar gk = 0; gk < K; gk++) begin : g_cell
            localparam int CI = (gr + DR * gk) * N + gc + DC * gk;
            assign is1[gk] = (board_q[2*CI +: 2] == 2'b01);
            assign is2[gk] = (board_q[2*CI +: 2] == 2'b10);
          end
          assign hit1[gr][gc][gd] = &is1;
          assign hit2[gr][gc][gd] = &is2;
        end else begin : g_off
          assign hit1[gr][gc][gd] = 1'b0;
          assign hit2[gr][gc][gd] = 1'b0;
        end
      end
    end
  end

  assign cur1      = hit1[row_q][col_q];
  assign cur2      = hit2[row_q][col_q];
  assign last_cell = (row_q == AW'(N - 1)) && (col_q == AW'(N - 1));

  function automatic logic [1:0] first_dir(input logic [3:0] v);
    if (v[0]) return 2'd0;
    if (v[1]) return 2'd1;
    if (v[2]) return 2'd2;
    return 2'd3;
  endfunction

  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    has_empty   = 1'b0;
    has_illegal = 1'b0;
    for (int i = 0; i < NC; i++) begin
      if (board_q[2*i +: 2] == 2'b00) has_empty   = 1'b1;
      if (board_q[2*i +: 2] == 2'b11) has_illegal = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = SCAN;
      SCAN:    if (last_cell) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the board copy is a plain register, so it is reset with the rest.
      board_q   <= '0;
      row_q     <= '0;
      col_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      winner_q  <= 2'b00;
      wrow_q    <= '0;
      wcol_q    <= '0;
      dir_q     <= 2'b00;
      draw_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      busy_q <= (state_q == SCAN);
      done_q <= (state_q == DONE);
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            board_q   <= bus.board;
            row_q     <= '0;
            col_q     <= '0;
            winner_q  <= 2'b00;
            wrow_q    <= '0;
            wcol_q    <= '0;
            dir_q     <= 2'b00;
            draw_q    <= 1'b0;
            illegal_q <= 1'b0;
          end
        end
        SCAN: begin
          // A player-1 line replaces a recorded player-2 line; otherwise the
          // first recorded line is kept.
          if ((|cur1) && (winner_q != 2'b01)) begin
            winner_q <= 2'b01;
            wrow_q   <= row_q;
            wcol_q   <= col_q;
            dir_q    <= first_dir(cur1);
          end else if ((|cur2) && (winner_q == 2'b00)) begin
            winner_q <= 2'b10;
            wrow_q   <= row_q;
            wcol_q   <= col_q;
            dir_q    <= first_dir(cur2);
          end
          if (last_cell) begin
            row_q <= '0;
            col_q <= '0;
          end else if (col_q == AW'(N - 1)) begin
            col_q <= '0;
            row_q <= row_q + 1'b1;
          end else begin
            col_q <= col_q + 1'b1;
          end
        end
        DONE: begin
          draw_q    <= (winner_q == 2'b00) && !has_empty;
          illegal_q <= has_illegal;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.winner  = winner_q;
  assign bus.draw    = draw_q;
  assign bus.illegal = illegal_q;
  assign bus.win_row = wrow_q;
  assign bus.win_col = wcol_q;
  assign bus.win_dir = dir_q;

endmodule

// File: tb/tb_board_judge.sv
// Bench for board_judge: a 3x3/K=3 and a 5x5/K=4 instance, table vectors,
// hand-written handshake/reset sequences and random boards against a line-search model.
module tb_board_judge;

  typedef struct packed {
    logic [1:0] winner;
    logic [2:0] row;
    logic [2:0] col;
    logic [1:0] dir;
    logic       draw;
    logic       illegal;
  } res_t;

  typedef struct {
    int    sel;
    string cells;
    res_t  exp;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  board_judge_if #(.N(3)) if3 ();
  board_judge_if #(.N(5)) if5 ();

  board_judge #(.N(3), .K(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));
  board_judge #(.N(5), .K(4)) u_dut5 (.clk(clk), .rst_n(rst_n), .bus(if5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [49:0] to_board(input string s);
    logic [49:0] b;
    b = '0;
    for (int i = 0; i < s.len(); i++) b[2*i +: 2] = 2'(s[i] - 8'd48);
    return b;
  endfunction

  function automatic res_t mkres(input int w, input int r, input int c, input int d,
                                 input int dr, input int il);
    res_t x;
    x.winner = 2'(w); x.row = 3'(r); x.col = 3'(c); x.dir = 2'(d);
    x.draw = 1'(dr); x.illegal = 1'(il);
    return x;
  endfunction

  function automatic vec_t mkv(input int sel, input string s, input res_t e);
    vec_t v;
    v.sel = sel; v.cells = s; v.exp = e;
    return v;
  endfunction

  // Reference: look for any player-1 line over the whole board first, then
  // player 2; within a player the first cell/direction in scan order is taken.
  function automatic res_t model(input int n, input int k, input logic [49:0] b);
    res_t res;
    bit   found, empty, ill, ok;
    int   dr, dc, er, ec;
    res = '0; found = 0; empty = 0; ill = 0;
    for (int p = 1; p <= 2; p++) begin
      for (int i = 0; i < n*n; i++) begin
        for (int d = 0; d < 4; d++) begin
          dr = (d == 0) ? 0 : 1;
          dc = (d == 1) ? 0 : ((d == 3) ? -1 : 1);
          er = i / n + dr * (k - 1);
          ec = i % n + dc * (k - 1);
          if (!found && er < n && ec >= 0 && ec < n) begin
            ok = 1;
            for (int j = 0; j < k; j++)
              if (b[2*((i / n + dr*j) * n + i % n + dc*j) +: 2] != 2'(p)) ok = 0;
            if (ok) begin
              found = 1;
              res.winner = 2'(p); res.row = 3'(i / n); res.col = 3'(i % n); res.dir = 2'(d);
            end
          end
        end
      end
    end
    for (int i = 0; i < n*n; i++) begin
      if (b[2*i +: 2] == 2'b00) empty = 1;
      if (b[2*i +: 2] == 2'b11) ill = 1;
    end
    res.draw = !found && !empty;
    res.illegal = ill;
    return res;
  endfunction

  function automatic res_t get_res(input int sel);
    res_t r;
    if (sel == 0) begin
      r.winner = if3.winner; r.row = 3'(if3.win_row); r.col = 3'(if3.win_col);
      r.dir = if3.win_dir; r.draw = if3.draw; r.illegal = if3.illegal;
    end else begin
      r.winner = if5.winner; r.row = if5.win_row; r.col = if5.win_col;
      r.dir = if5.win_dir; r.draw = if5.draw; r.illegal = if5.illegal;
    end
    return r;
  endfunction

  function automatic logic cur_busy(input int sel);
    return (sel == 0) ? if3.busy : if5.busy;
  endfunction

  function automatic logic cur_done(input int sel);
    return (sel == 0) ? if3.done : if5.done;
  endfunction

  task automatic drive(input int sel, input logic [49:0] b, input logic s);
    if (sel == 0) begin if3.board = b[17:0]; if3.start = s; end
    else          begin if5.board = b;       if5.start = s; end
  endtask

  task automatic compare_res(input string tag, input res_t got, input res_t exp);
    check({tag, ".winner"},  32'(got.winner),  32'(exp.winner));
    check({tag, ".win_row"}, 32'(got.row),     32'(exp.row));
    check({tag, ".win_col"}, 32'(got.col),     32'(exp.col));
    check({tag, ".win_dir"}, 32'(got.dir),     32'(exp.dir));
    check({tag, ".draw"},    32'(got.draw),    32'(exp.draw));
    check({tag, ".illegal"}, 32'(got.illegal), 32'(exp.illegal));
  endtask

  // One start pulse; counts edges from the accepting edge to the done pulse.
  task automatic run_and_compare(input int sel, input logic [49:0] b, input res_t exp,
                                 input string tag);
    int   n;
    int   lat;
    int   busy_n;
    bit   got;
    res_t r;
    n = (sel != 0) ? 5 : 3;
    @(negedge clk);
    drive(sel, b, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(sel, b, 1'b0);
    lat = 0; busy_n = 0; got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (cur_busy(sel)) busy_n++;
      if (cur_done(sel)) got = 1;
    end
    check({tag, ".timeout"}, 32'(got), 32'd1);
    check({tag, ".latency"}, 32'(lat), 32'(n*n + 1));
    check({tag, ".busy_cycles"}, 32'(busy_n), 32'(n*n));
    r = get_res(sel);
    compare_res(tag, r, exp);
    @(negedge clk);
    check({tag, ".done_one_cycle"}, 32'(cur_done(sel)), 32'd0);
    check({tag, ".held"}, 32'(get_res(sel)), 32'(exp));
  endtask

  task automatic check_quiet(input int sel, input string tag);
    check(tag, {cur_busy(sel), cur_done(sel), 32'(get_res(sel))}, 32'd0);
  endtask

  initial begin
    vec_t        vecs[$];
    logic [49:0] b;
    logic [49:0] ba;
    int          v;
    int          dones;
    int          busy_n;
    bit          got;

    checks = 0; errors = 0;
    rst_n = 1'b0;
    if3.start = 1'b0; if3.board = '0;
    if5.start = 1'b0; if5.board = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_quiet(0, "reset3");
    check_quiet(1, "reset5");
    rst_n = 1'b1;

    vecs.push_back(mkv(0, "111000000", mkres(1, 0, 0, 0, 0, 0)));
    vecs.push_back(mkv(0, "210210210", mkres(1, 0, 1, 1, 0, 0)));
    vecs.push_back(mkv(0, "222000111", mkres(1, 2, 0, 0, 0, 0)));
    vecs.push_back(mkv(0, "121122211", mkres(0, 0, 0, 0, 1, 0)));
    vecs.push_back(mkv(0, "121102211", mkres(0, 0, 0, 0, 0, 0)));
    vecs.push_back(mkv(0, "000000000", mkres(0, 0, 0, 0, 0, 0)));
    vecs.push_back(mkv(0, "333333333", mkres(0, 0, 0, 0, 1, 1)));
    vecs.push_back(mkv(0, "200020002", mkres(2, 0, 0, 2, 0, 0)));
    vecs.push_back(mkv(0, "002020200", mkres(2, 0, 2, 3, 0, 0)));
    vecs.push_back(mkv(0, "001111001", mkres(1, 0, 2, 1, 0, 0)));
    vecs.push_back(mkv(0, "100110111", mkres(1, 0, 0, 1, 0, 0)));
    vecs.push_back(mkv(0, "313101323", mkres(0, 0, 0, 0, 0, 1)));
    vecs.push_back(mkv(1, "0000000002000200020002000", mkres(2, 1, 4, 3, 0, 0)));
    vecs.push_back(mkv(1, "3000000002000200020002000", mkres(2, 1, 4, 3, 0, 1)));
    vecs.push_back(mkv(1, "0000002220011110000000000", mkres(1, 2, 1, 0, 0, 0)));
    vecs.push_back(mkv(1, "1110000000000000000000000", mkres(0, 0, 0, 0, 0, 0)));

    foreach (vecs[i])
      run_and_compare(vecs[i].sel, to_board(vecs[i].cells), vecs[i].exp,
                      $sformatf("vec%0d", i));

    // start held high with the board changing mid-scan: one judgement of the E0 board
    ba = to_board("020020020");
    @(negedge clk);
    drive(0, ba, 1'b1);
    @(posedge clk);
    dones = 0; busy_n = 0; got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      drive(0, 50'($urandom) | (50'($urandom) << 32), 1'b1);
      if (if3.done) begin got = 1; dones++; if3.start = 1'b0; end
      else if (if3.busy) busy_n++;
      if (!got) @(posedge clk);
    end
    check("held.timeout", 32'(got), 32'd1);
    check("held.busy_cycles", 32'(busy_n), 32'd9);
    compare_res("held", get_res(0), model(3, 3, ba));
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (if3.done) dones++;
    end
    check("held.done_count", 32'(dones), 32'd1);

    // reset mid-scan: outputs clear at once and the aborted scan never reports
    @(negedge clk);
    drive(0, to_board("111000000"), 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(0, to_board("111000000"), 1'b0);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_quiet(0, "midreset.clear");
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (if3.done) dones++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (if3.done) dones++;
    end
    check("midreset.no_done", 32'(dones), 32'd0);
    run_and_compare(0, to_board("200020002"), mkres(2, 0, 0, 2, 0, 0), "after_reset");

    for (int t = 0; t < 40; t++) begin
      b = '0;
      for (int i = 0; i < 9; i++) begin
        v = $urandom_range(0, 9);
        b[2*i +: 2] = (v < 3) ? 2'b00 : (v < 6) ? 2'b01 : (v < 9) ? 2'b10 : 2'b11;
      end
      run_and_compare(0, b, model(3, 3, b), $sformatf("rand3_%0d", t));
    end
    for (int t = 0; t < 25; t++) begin
      b = '0;
      for (int i = 0; i < 25; i++) begin
        v = $urandom_range(0, 10);
        b[2*i +: 2] = (v < 2) ? 2'b00 : (v < 6) ? 2'b01 : (v < 10) ? 2'b10 : 2'b11;
      end
      run_and_compare(1, b, model(5, 4, b), $sformatf("rand5_%0d", t));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
